wb_fmc516_ctrl: RTL and testbench

Simplified FMC516 4-channel ADC interface core with a classic (non-pipelined) Wishbone slave register bank.
- Registers the four ADC sample streams and can substitute a ramp test pattern.
- Captures the latest valid samples and counts valid samples.
- Exposes board status and control pins.
- Sits between the FMC516 capture front end, already synchronous to clk_sys_i, and the system Wishbone crossbar.

---
 rtl/wb_fmc516_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_wb_fmc516_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fmc516_ctrl.sv
// wb_fmc516_ctrl
// Simplified FMC516 4-channel ADC interface with a classic Wishbone slave
// register bank.
// - Registers the ADC sample streams, with an optional ramp test pattern.
// - Captures the latest valid samples and counts valid samples.
// - Exposes board status and control pins.
//
// Ports:
//   clk_sys_i, sys_rst_i        : system clock, synchronous active-high reset
//   wb_*                        : classic Wishbone slave (word addressed)
//   adc_data_ch0..3_i, _valid_i : incoming samples (already on clk_sys_i)
//   lmk/mmcm lock, pwr_good,
//   prsnt_m2c_l, m2c_trig       : board status inputs
//   adc_data_ch0..3_o, _valid_o : registered samples (1-cycle latency)
//   fmc_leds_o, fmc_clk_sel_o,
//   fmc_reset_adcs_n_o          : control outputs from CTL
//   trig_hw_o                   : registered trigger
//   fmc_mmcm_lock_o,
//   fmc_lmk_lock_o              : combinational passthroughs
//
// Register map (word address):
//   0 STA (RO)   1 CTL (RW)   2 DATA01 (RO)   3 DATA23 (RO)
//   4 VALID_CNT (RO)   5 SCRATCH (RW)   others read 0
module wb_fmc516_ctrl #(
  parameter int unsigned g_adc_data_width = 16,
  parameter int unsigned g_adr_width      = 4
) (
  input  logic                        clk_sys_i,
  input  logic                        sys_rst_i,
  input  logic [g_adr_width-1:0]      wb_adr_i,
  input  logic [31:0]                 wb_dat_i,
  output logic [31:0]                 wb_dat_o,
  input  logic [3:0]                  wb_sel_i,
  input  logic                        wb_we_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        wb_rty_o,
  output logic                        wb_stall_o,
  input  logic [g_adc_data_width-1:0] adc_data_ch0_i,
  input  logic [g_adc_data_width-1:0] adc_data_ch1_i,
  input  logic [g_adc_data_width-1:0] adc_data_ch2_i,
  input  logic [g_adc_data_width-1:0] adc_data_ch3_i,
  input  logic                        adc_data_valid_i,
  input  logic                        lmk_lock_i,
  input  logic                        mmcm_lock_i,
  input  logic                        fmc_pwr_good_i,
  input  logic                        fmc_prsnt_m2c_l_i,
  input  logic                        m2c_trig_i,
  output logic [g_adc_data_width-1:0] adc_data_ch0_o,
  output logic [g_adc_data_width-1:0] adc_data_ch1_o,
  output logic [g_adc_data_width-1:0] adc_data_ch2_o,
  output logic [g_adc_data_width-1:0] adc_data_ch3_o,
  output logic                        adc_data_valid_o,
  output logic [2:0]                  fmc_leds_o,
  output logic                        fmc_clk_sel_o,
  output logic                        fmc_reset_adcs_n_o,
  output logic                        trig_hw_o,
  output logic                        fmc_mmcm_lock_o,
  output logic                        fmc_lmk_lock_o
);

  localparam logic [g_adr_width-1:0] c_adr_sta     = g_adr_width'(0);
  localparam logic [g_adr_width-1:0] c_adr_ctl     = g_adr_width'(1);
  localparam logic [g_adr_width-1:0] c_adr_data01  = g_adr_width'(2);
  localparam logic [g_adr_width-1:0] c_adr_data23  = g_adr_width'(3);
  localparam logic [g_adr_width-1:0] c_adr_cnt     = g_adr_width'(4);
  localparam logic [g_adr_width-1:0] c_adr_scratch = g_adr_width'(5);

  logic                        r_ack;
  logic [31:0]                 r_dat_o;
  logic                        r_clk_sel;
  logic                        r_rst_adcs;
  logic [2:0]                  r_leds;
  logic                        r_test_mode;
  logic [31:0]                 r_scratch;
  logic [31:0]                 r_valid_cnt;
  logic [g_adc_data_width-1:0] r_ramp;
  logic [g_adc_data_width-1:0] r_ch_out [4];
  logic [15:0]                 r_data   [4];
  logic                        r_valid_out;
  logic                        r_trig;

  logic                        w_acc;
  logic                        w_wr;
  logic                        w_ctl_wr;
  logic                        w_cnt_clr;
  logic [31:0]                 w_rd_data;
  logic [g_adc_data_width-1:0] w_ch_in   [4];
  logic [g_adc_data_width-1:0] w_ch_next [4];
  logic [15:0]                 w_ch_ext  [4];

  // New access only when no ack is outstanding: gives 2-cycle accesses
  // and a single-cycle ack pulse.
  assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_ctl_wr  = w_wr & (wb_adr_i == c_adr_ctl) & wb_sel_i[0];
  assign w_cnt_clr = w_ctl_wr & wb_dat_i[7];

  assign w_ch_in[0] = adc_data_ch0_i;
  assign w_ch_in[1] = adc_data_ch1_i;
  assign w_ch_in[2] = adc_data_ch2_i;
  assign w_ch_in[3] = adc_data_ch3_i;

  // Sample selected for the output stage; the DATA capture uses the same
  // value, zero-extended to 16 bits.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_ch_next[i] = r_test_mode ? (r_ramp + g_adc_data_width'(i)) : w_ch_in[i];
      w_ch_ext[i]  = '0;
      w_ch_ext[i][g_adc_data_width-1:0] = w_ch_next[i];
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (wb_adr_i)
      c_adr_sta:     w_rd_data = {28'd0, ~fmc_prsnt_m2c_l_i, fmc_pwr_good_i,
                                  lmk_lock_i, mmcm_lock_i};
      c_adr_ctl:     w_rd_data = {26'd0, r_test_mode, r_leds, r_rst_adcs, r_clk_sel};
      c_adr_data01:  w_rd_data = {r_data[1], r_data[0]};
      c_adr_data23:  w_rd_data = {r_data[3], r_data[2]};
      c_adr_cnt:     w_rd_data = r_valid_cnt;
      c_adr_scratch: w_rd_data = r_scratch;
      default:       w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (sys_rst_i) begin
      r_ack       <= 1'b0;
      r_dat_o     <= '0;
      r_clk_sel   <= 1'b0;
      r_rst_adcs  <= 1'b0;
      r_leds      <= '0;
      r_test_mode <= 1'b0;
      r_scratch   <= '0;
      r_valid_cnt <= '0;
      r_ramp      <= '0;
      r_valid_out <= 1'b0;
      r_trig      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_ch_out[i] <= '0;
        r_data[i]   <= '0;
      end
    end else begin
      r_ack <= w_acc;
      if (w_acc && !wb_we_i) begin
        r_dat_o <= w_rd_data;
      end

      if (w_ctl_wr) begin
        r_clk_sel   <= wb_dat_i[0];
        r_rst_adcs  <= wb_dat_i[1];
        r_leds      <= wb_dat_i[4:2];
        r_test_mode <= wb_dat_i[5];
      end

      if (w_wr && (wb_adr_i == c_adr_scratch)) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (wb_sel_i[k]) begin
            r_scratch[8*k +: 8] <= wb_dat_i[8*k +: 8];
          end
        end
      end

      // Clear has priority over a coincident valid sample.
      if (w_cnt_clr) begin
        r_valid_cnt <= '0;
      end else if (adc_data_valid_i) begin
        r_valid_cnt <= r_valid_cnt + 32'd1;
      end

      if (adc_data_valid_i) begin
        r_ramp <= r_ramp + 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
          r_data[i] <= w_ch_ext[i];
        end
      end

      for (int unsigned i = 0; i < 4; i++) begin
        r_ch_out[i] <= w_ch_next[i];
      end
      r_valid_out <= adc_data_valid_i;
      r_trig      <= m2c_trig_i;
    end
  end

  assign wb_ack_o           = r_ack;
  assign wb_dat_o           = r_dat_o;
  assign wb_err_o           = 1'b0;
  assign wb_rty_o           = 1'b0;
  assign wb_stall_o         = 1'b0;
  assign adc_data_ch0_o     = r_ch_out[0];
  assign adc_data_ch1_o     = r_ch_out[1];
  assign adc_data_ch2_o     = r_ch_out[2];
  assign adc_data_ch3_o     = r_ch_out[3];
  assign adc_data_valid_o   = r_valid_out;
  assign fmc_leds_o         = r_leds;
  assign fmc_clk_sel_o      = r_clk_sel;
  assign fmc_reset_adcs_n_o = ~r_rst_adcs;
  assign trig_hw_o          = r_trig;
  assign fmc_mmcm_lock_o    = mmcm_lock_i;
  assign fmc_lmk_lock_o     = lmk_lock_i;

endmodule

// File: tb/tb_wb_fmc516_ctrl.sv
// Testbench for wb_fmc516_ctrl: Wishbone reads are checked by a scoreboard
// monitor against a behavioural model of the register bank; the sample
// datapath and control pins are checked cycle by cycle against the model.
module tb_wb_fmc516_ctrl;

  localparam int W = 16;
  localparam int unsigned MASK = (32'd1 << W) - 32'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack, err, rty, stall;
  logic [W-1:0] ch_i [4];
  logic [W-1:0] ch_o [4];
  logic        valid_i, valid_o;
  logic        lmk, mmcm, pwr, prsnt_l, trig;
  logic [2:0]  leds;
  logic        clk_sel, rst_adcs_n, trig_o, mmcm_o, lmk_o;

  always #5 clk = ~clk;

  wb_fmc516_ctrl #(.g_adc_data_width(W), .g_adr_width(4)) dut (
    .clk_sys_i(clk), .sys_rst_i(rst),
    .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall),
    .adc_data_ch0_i(ch_i[0]), .adc_data_ch1_i(ch_i[1]),
    .adc_data_ch2_i(ch_i[2]), .adc_data_ch3_i(ch_i[3]),
    .adc_data_valid_i(valid_i),
    .lmk_lock_i(lmk), .mmcm_lock_i(mmcm), .fmc_pwr_good_i(pwr),
    .fmc_prsnt_m2c_l_i(prsnt_l), .m2c_trig_i(trig),
    .adc_data_ch0_o(ch_o[0]), .adc_data_ch1_o(ch_o[1]),
    .adc_data_ch2_o(ch_o[2]), .adc_data_ch3_o(ch_o[3]),
    .adc_data_valid_o(valid_o),
    .fmc_leds_o(leds), .fmc_clk_sel_o(clk_sel),
    .fmc_reset_adcs_n_o(rst_adcs_n), .trig_hw_o(trig_o),
    .fmc_mmcm_lock_o(mmcm_o), .fmc_lmk_lock_o(lmk_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_scratch, m_cnt, m_ramp;
  bit          m_clk_sel, m_rst_adcs, m_test_mode;
  int unsigned m_leds;
  int unsigned m_data [4];

  function automatic logic [31:0] model_read(input int unsigned a);
    case (a)
      0: return {28'd0, ~prsnt_l, pwr, lmk, mmcm};
      1: return 32'(m_test_mode) << 5 | m_leds << 2 | 32'(m_rst_adcs) << 1 | 32'(m_clk_sel);
      2: return (m_data[1] << 16) | m_data[0];
      3: return (m_data[3] << 16) | m_data[2];
      4: return m_cnt;
      5: return m_scratch;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(input int unsigned a, input logic [31:0] d,
                                      input logic [3:0] s);
    if (a == 1 && s[0]) begin
      m_clk_sel   = d[0];
      m_rst_adcs  = d[1];
      m_leds      = 32'(d[4:2]);
      m_test_mode = d[5];
      if (d[7]) m_cnt = 0;
    end
    if (a == 5) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) m_scratch[8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { int unsigned adr; logic [31:0] dat; } rd_t;
  rd_t exp_q [$];

  always @(negedge clk) begin
    if (ack && exp_q.size() > 0) begin
      rd_t e;
      e = exp_q.pop_front();
      chk($sformatf("rd_adr%0d", e.adr), dat_r, e.dat);
    end
  end

  task automatic wb_xfer(input bit w, input int unsigned a, input logic [31:0] d,
                         input logic [3:0] s);
    int n;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = 4'(a); dat_w = d; sel = s;
    if (w) model_write(a, d, s);
    else   exp_q.push_back('{a, model_read(a)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("ack_pulse", 32'(ack), 32'd0);
  endtask

  // One sample cycle: caller is at a negedge; outputs checked one cycle later.
  task automatic adc_cycle(input bit v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3);
    int unsigned e [4];
    logic [W-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      e[i] = m_test_mode ? ((m_ramp + 32'(i)) & MASK) : (32'(d[i]) & MASK);
      ch_i[i] = d[i];
    end
    valid_i = v;
    if (v) begin
      for (int i = 0; i < 4; i++) m_data[i] = e[i];
      m_cnt++;
      m_ramp = (m_ramp + 1) & MASK;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("ch%0d_o", i), 32'(ch_o[i]), e[i]);
    chk("valid_o", 32'(valid_o), 32'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; adr = '0; dat_w = '0; sel = '0; we = 0; cyc = 0; stb = 0;
    for (int i = 0; i < 4; i++) ch_i[i] = '0;
    valid_i = 0; lmk = 1; mmcm = 1; pwr = 1; prsnt_l = 0; trig = 0;
    m_scratch = 0; m_cnt = 0; m_ramp = 0; m_clk_sel = 0; m_rst_adcs = 0;
    m_test_mode = 0; m_leds = 0;
    for (int i = 0; i < 4; i++) m_data[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat_o", dat_r, 32'd0);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_ch0_o", 32'(ch_o[0]), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_clk_sel", 32'(clk_sel), 32'd0);
    chk("rst_adcs_n", 32'(rst_adcs_n), 32'd1);
    chk("rst_trig", 32'(trig_o), 32'd0);
    rst = 0;

    for (int a = 0; a < 16; a++) wb_xfer(0, a, '0, 4'hF);
    chk("adcs_n_after_reads", 32'(rst_adcs_n), 32'd1);
    chk("tied_err_rty_stall", {29'd0, err, rty, stall}, 32'd0);

    // Byte-masked SCRATCH write.
    wb_xfer(1, 5, 32'hDEADBEEF, 4'b0101);
    chk("model_scratch", m_scratch, 32'h00AD00EF);
    wb_xfer(0, 5, '0, 4'hF);

    // Directed sample.
    adc_cycle(1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    adc_cycle(0, 16'h0, 16'h0, 16'h0, 16'h0);
    wb_xfer(0, 2, '0, 4'hF);
    wb_xfer(0, 3, '0, 4'hF);
    wb_xfer(0, 4, '0, 4'hF);

    // Random samples, valid 50%.
    for (int n = 0; n < 10; n++)
      adc_cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                W'($urandom), W'($urandom));
    adc_cycle(0, '0, '0, '0, '0);
    wb_xfer(0, 4, '0, 4'hF);
    wb_xfer(0, 2, '0, 4'hF);

    // cnt_clr coincident with a valid sample: clear wins.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ch_i[i] = W'($urandom);
      m_data[i] = 32'(ch_i[i]) & MASK;
    end
    valid_i = 1; m_ramp = (m_ramp + 1) & MASK;
    cyc = 1; stb = 1; we = 1; adr = 4'd1; dat_w = 32'h80; sel = 4'h1;
    model_write(1, 32'h80, 4'h1);
    @(negedge clk);
    valid_i = 0;
    chk("clr_ack", 32'(ack), 32'd1);
    cyc = 0; stb = 0; we = 0;
    wb_xfer(0, 4, '0, 4'hF);
    wb_xfer(0, 1, '0, 4'hF);
    wb_xfer(0, 2, '0, 4'hF);

    // Test mode / control outputs.
    wb_xfer(1, 1, 32'h0000003F, 4'hF);
    chk("leds", 32'(leds), 32'd7);
    chk("clk_sel", 32'(clk_sel), 32'd1);
    chk("adcs_n_asserted", 32'(rst_adcs_n), 32'd0);
    wb_xfer(0, 1, '0, 4'hF);
    for (int n = 0; n < 4; n++)
      adc_cycle(1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    adc_cycle(0, '0, '0, '0, '0);
    wb_xfer(0, 2, '0, 4'hF);
    wb_xfer(0, 3, '0, 4'hF);
    wb_xfer(0, 4, '0, 4'hF);

    // Status inputs and passthroughs.
    mmcm = 1; lmk = 0; pwr = 1; prsnt_l = 0;
    wb_xfer(0, 0, '0, 4'hF);
    chk("model_sta", model_read(0), 32'h0000000D);
    chk("mmcm_pass", 32'(mmcm_o), 32'(mmcm));
    chk("lmk_pass", 32'(lmk_o), 32'(lmk));

    // Trigger follows one cycle later.
    @(negedge clk);
    trig = 1;
    chk("trig_pre", 32'(trig_o), 32'd0);
    @(negedge clk);
    trig = 0;
    chk("trig_hi", 32'(trig_o), 32'd1);
    @(negedge clk);
    chk("trig_lo", 32'(trig_o), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
